// File: rtl/reflet_hardware_info_timebase.sv
// rtl/reflet_hardware_info_timebase.sv - hardware info bytes plus millisecond uptime counter with snapshot
module reflet_hardware_info_timebase #(
  parameter int wordsize = 16,
  parameter int base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr = 'hFF00,
  parameter int enable_exti = 1,
  parameter int enable_gpio = 1,
  parameter int enable_timer = 1,
  parameter int enable_timer2 = 1,
  parameter int enable_uart = 1,
  parameter int enable_pwm = 1,
  parameter int enable_segments = 1,
  parameter int clk_freq = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out
);

  localparam int          DIV      = clk_freq / 1000;
  localparam logic [31:0] div_last = 32'(DIV - 1);
  localparam logic [23:0] khz      = 24'(clk_freq / 1000);
  localparam logic [2:0]  ws       = (wordsize == 8)   ? 3'd1 :
                                     (wordsize == 16)  ? 3'd2 :
                                     (wordsize == 32)  ? 3'd3 :
                                     (wordsize == 64)  ? 3'd4 :
                                     (wordsize == 128) ? 3'd5 : 3'd0;
  localparam logic [7:0]  info_ws  = {enable_uart != 0, enable_timer2 != 0, enable_timer != 0,
                                      enable_gpio != 0, enable_exti != 0, ws};
  localparam logic [7:0]  info_per = {6'h0, enable_segments != 0, enable_pwm != 0};

  logic [31:0] pre;
  logic [31:0] ms_cnt;
  logic [31:0] shadow;
  logic        freeze;

  logic [base_addr_size-1:0] diff;
  logic [3:0]                off;
  logic                      sel;
  logic                      tick;
  logic                      ctrl_wr;
  logic                      snap;
  logic                      unused_bits;

  // Window test via subtraction so base_addr+15 never has to be representable
  assign diff    = addr - base_addr;
  assign off     = diff[3:0];
  assign sel     = enable && (addr >= base_addr) && ((diff >> 4) == '0);
  assign tick    = (pre == div_last);
  assign ctrl_wr = sel && write_en && (off == 4'd5);
  assign snap    = sel && !write_en && (off == 4'd8);

  assign unused_bits = ^{data_in[7:2], shadow[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      pre    <= '0;
      ms_cnt <= '0;
      shadow <= '0;
      freeze <= 1'b0;
    end else begin
      if (ctrl_wr) freeze <= data_in[0];
      // Clear wins over both counting and the freeze that was in force this cycle
      if (ctrl_wr && data_in[1]) begin
        pre    <= '0;
        ms_cnt <= '0;
      end else if (!freeze) begin
        if (tick) begin
          pre    <= '0;
          ms_cnt <= ms_cnt + 32'd1;
        end else begin
          pre <= pre + 32'd1;
        end
      end
      if (snap) shadow <= ms_cnt;
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (sel && !write_en) begin
      case (off)
        4'd0:    data_out = khz[7:0];
        4'd1:    data_out = khz[15:8];
        4'd2:    data_out = khz[23:16];
        4'd3:    data_out = info_ws;
        4'd4:    data_out = info_per;
        4'd5:    data_out = {7'h0, freeze};
        4'd8:    data_out = ms_cnt[7:0];
        4'd9:    data_out = shadow[15:8];
        4'd10:   data_out = shadow[23:16];
        4'd11:   data_out = shadow[31:24];
        default: data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_hardware_info_timebase.sv
// tb/tb_reflet_hardware_info_timebase.sv - directed self-checking bench for reflet_hardware_info_timebase
module tb_reflet_hardware_info_timebase;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] addr;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;

  int n_cmp = 0;
  int n_bad = 0;

  reflet_hardware_info_timebase #(
    .wordsize(16),
    .base_addr_size(16),
    .base_addr(BASE),
    .clk_freq(4000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .addr(addr),
    .write_en(write_en),
    .data_in(data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check_byte(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic idle();
    enable   = 1'b0;
    write_en = 1'b0;
    addr     = 16'h0000;
    data_in  = 8'h00;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] off, input string tag, input logic [7:0] exp);
    enable   = 1'b1;
    write_en = 1'b0;
    addr     = BASE + {12'h000, off};
    #1;
    check_byte(tag, data_out, exp);
  endtask

  // Drives one write across a single rising edge, returns at the following negedge idle
  task automatic wr(input logic [3:0] off, input logic [7:0] d);
    enable   = 1'b1;
    write_en = 1'b1;
    addr     = BASE + {12'h000, off};
    data_in  = d;
    @(negedge clk);
    idle();
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    idle();
    step(3);

    // static bytes and decode, readable while in reset
    rd(4'd0, "khz0", 8'h04);
    rd(4'd1, "khz1", 8'h00);
    rd(4'd2, "khz2", 8'h00);
    rd(4'd3, "info_ws", 8'hFA);
    rd(4'd4, "info_per", 8'h03);
    rd(4'd6, "rsvd6", 8'h00);
    rd(4'd12, "rsvd12", 8'h00);
    rd(4'd5, "ctrl_rst", 8'h00);
    addr = BASE - 16'd1; #1;
    check_byte("below_base", data_out, 8'h00);
    addr = BASE + 16'd16; #1;
    check_byte("above_win", data_out, 8'h00);
    addr = BASE; write_en = 1'b1; #1;
    check_byte("read_on_write", data_out, 8'h00);
    write_en = 1'b0; enable = 1'b0; #1;
    check_byte("not_enabled", data_out, 8'h00);
    idle();

    // 400 cycles at DIV=4 -> 100 ms
    reset = 1'b0;
    step(400);
    rd(4'd8, "up400_b0", 8'h64);
    step(1);
    rd(4'd9, "up400_b1", 8'h00);
    idle();
    step(2);
    rd(4'd8, "pre3_hold", 8'h64);
    idle();
    step(1);
    rd(4'd8, "tick_4th", 8'h65);

    // freeze holds both prescaler and count
    wr(4'd5, 8'h01);
    rd(4'd5, "ctrl_frz", 8'h01);
    idle();
    step(100);
    rd(4'd8, "frozen", 8'h65);
    idle();
    wr(4'd5, 8'h00);
    rd(4'd5, "ctrl_run", 8'h00);
    idle();
    step(2);
    rd(4'd8, "resume_pre", 8'h65);
    idle();
    step(1);
    rd(4'd8, "resume_tick", 8'h66);
    idle();

    // snapshot coherence across 0xFF -> 0x100
    step(615);
    rd(4'd8, "ff_live", 8'hFF);
    step(1);
    rd(4'd9, "snap_b1_ff", 8'h00);
    rd(4'd8, "live_after", 8'h00);
    step(1);
    rd(4'd9, "relatch_b1", 8'h01);
    rd(4'd10, "relatch_b2", 8'h00);
    idle();

    // clear on a tick cycle
    step(2);
    wr(4'd5, 8'h02);
    rd(4'd5, "clr_selfclr", 8'h00);
    rd(4'd8, "clr_cnt", 8'h00);
    idle();
    step(3);
    rd(4'd8, "clr_pre0", 8'h00);
    idle();
    step(1);
    rd(4'd8, "clr_tick", 8'h01);
    idle();

    // clear plus freeze together, other-offset writes ignored
    wr(4'd5, 8'h03);
    rd(4'd5, "clrfrz_ctrl", 8'h01);
    rd(4'd8, "clrfrz_cnt", 8'h00);
    idle();
    step(10);
    rd(4'd8, "clrfrz_hold", 8'h00);
    idle();
    wr(4'd4, 8'h00);
    rd(4'd5, "wr_other_ign", 8'h01);
    idle();
    wr(4'd5, 8'h00);

    // 32-bit wrap
    step(3);
    force dut.ms_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.ms_cnt;
    rd(4'd8, "wrap_pre", 8'hFF);
    step(1);
    rd(4'd9, "wrap_snap1", 8'hFF);
    rd(4'd11, "wrap_snap3", 8'hFF);
    rd(4'd8, "wrap_live", 8'h00);
    idle();

    // reset mid-count clears everything including prescaler phase
    step(6);
    rd(4'd8, "pre_reset", 8'h01);
    reset = 1'b1;
    step(1);
    rd(4'd8, "rst_cnt", 8'h00);
    rd(4'd9, "rst_shadow", 8'h00);
    rd(4'd0, "rst_khz0", 8'h04);
    idle();
    reset = 1'b0;
    step(3);
    rd(4'd8, "rst_pre0", 8'h00);
    idle();
    step(1);
    rd(4'd8, "rst_tick", 8'h01);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
